lm_sm_sequencer: RTL and testbench
==================================

// Module: lm_sm_sequencer
// PURPOSE
//  Multi-cycle controller for load-multiple (LM) and store-multiple (SM) instructions.
//  Sits between the IF/ID pipeline register and the decode stage.
//  Expands one LM/SM into a sequence of single-register micro-ops, one per set bit
//  of IR[7:0]. While it does so it holds PC and IF/ID and drives the first_multiple
//  tag, which tells execute to take the base address from the RF rather than the
//  incremented-address path.
// PARAMETERS
//  OPC_LM   4'b0110   opcode of load-multiple
//  OPC_SM   4'b0111   opcode of store-multiple
//  NOP_IR   16'hF000  bubble instruction issued for an empty register list
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  ir_in           in   16  instruction currently held in IF/ID
//  ir_valid        in   1   ir_in is a real instruction (not a bubble)
//  stall           in   1   hazard unit holds decode; the sequencer freezes
//  flush           in   1   branch/jump flush of IF/ID; aborts any sequence
//  ir_out          out  16  instruction presented to decode
//  first_multiple  out  1   ir_out is the first micro-op of an LM/SM
//  last_multiple   out  1   ir_out is the final micro-op of an LM/SM
//  pc_write        out  1   PC update enable (0 = hold PC)
//  if_id_write     out  1   IF/ID load enable (0 = hold IF/ID)
//  busy            out  1   in SEQ state
// BEHAVIOUR
//  - Register list: bit 7 maps to R0 and bit 0 maps to R7. Bits are issued MSB first.
//  - Micro-op format: {IR[15:12], IR[11:9], 1'b0, onehot8}. onehot8 is the current bit only.
//  - State: FSM {IDLE, SEQ} plus an 8-bit register rem_mask. All outputs are combinational from state, rem_mask and ir_in.
//  - Reset (reset==0): state=IDLE and rem_mask=0, immediately (async).
//    Outputs while in reset: ir_out=NOP_IR, pc_write=1, if_id_write=1, first=0, last=0, busy=0.
//  - IDLE, ir_valid=0, or opcode not LM/SM:
//    ir_out=ir_in, pc_write=1, if_id_write=1, first=0, last=0.
//  - IDLE, LM/SM with IR[7:0]==0:
//    ir_out=NOP_IR, no hold, state stays IDLE.
//  - IDLE, LM/SM with k>=1 set bits:
//    ir_out=micro-op for the highest set bit, first_multiple=1.
//    If k==1: last_multiple=1, no hold, state stays IDLE.
//    If k>1: pc_write=0, if_id_write=0, rem_mask<=list minus the issued bit, state<=SEQ.
//  - SEQ:
//    ir_out=micro-op for the highest bit of rem_mask, first=0, busy=1.
//    If this is the last bit: last=1, pc_write=1, if_id_write=1, state<=IDLE, rem_mask<=0.
//    Otherwise: hold PC and IF/ID, and clear the issued bit from rem_mask.
//    ir_in/ir_valid are ignored in SEQ because IF/ID is held.
//  - Latency: an LM/SM with k set bits occupies decode for exactly k unstalled cycles.
//    The next instruction reaches decode in cycle k+1.
//  - stall=1 (no flush): state and rem_mask are frozen, ir_out/first/last are unchanged,
//    and pc_write=if_id_write=0 regardless of state.
//  - flush=1: flush has priority over stall.
//    Next state=IDLE, rem_mask<=0, pc_write=1, if_id_write=1.
//    The current micro-op is discarded by the IF/ID/ID-RR flush.
//  - Reset asserted mid-sequence aborts immediately. No partial-state recovery.
// TESTING
//  1. ADD 0x1234 in IDLE -> ir_out=0x1234 in the same cycle, pc_write=1, first=last=0.
//  2. LM 0x64A1 (base R2) -> three micro-ops:
//     cycle 0: 0x6480, first=1. cycle 1: 0x6420. cycle 2: 0x6401, last=1.
//     pc_write is 0 in cycles 0-1 and 1 in cycle 2; busy is 1 in cycles 1-2.
//  3. SM 0x7E01 -> one cycle with ir_out=0x7E01, first=last=1, pc_write=1, busy=0.
//     LM 0x6000 -> ir_out=0xF000, no hold.
//  4. LM 0x64FF with stall=1 for 2 cycles while 0x6420 is issued:
//     ir_out holds 0x6420 for 3 cycles, the sequence completes with 0x6401, 10 cycles in total.
//  5. LM 0x64FF with flush=1 in cycle 1 (stall also 1) -> in cycle 2: IDLE, busy=0,
//     pc_write=1, and ir_out equals the new ir_in.
//  6. reset driven low asynchronously mid-sequence -> outputs go to reset values before the next clk edge.
//     After release, a fresh LM issues from its first bit with first_multiple=1.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM micro-op sequencer between IF/ID and decode
//
// Expands a load-multiple / store-multiple instruction into one single-register
// micro-op per set bit of IR[7:0], issued MSB first (bit 7 = R0 ... bit 0 = R7).
// While a sequence is in flight, PC and IF/ID are held so ir_in stays stable.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   ir_in[15:0]    in   instruction held in IF/ID
//   ir_valid       in   ir_in is a real instruction
//   stall          in   hazard hold of decode; sequencer freezes
//   flush          in   IF/ID flush; aborts any sequence (wins over stall)
//   ir_out[15:0]   out  instruction presented to decode
//   first_multiple out  ir_out is the first micro-op of an LM/SM
//   last_multiple  out  ir_out is the final micro-op of an LM/SM
//   pc_write       out  PC update enable
//   if_id_write    out  IF/ID load enable
//   busy           out  sequencer is in SEQ
module lm_sm_sequencer #(
  parameter logic [3:0]  OPC_LM = 4'b0110,
  parameter logic [3:0]  OPC_SM = 4'b0111,
  parameter logic [15:0] NOP_IR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        ir_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] ir_out,
  output logic        first_multiple,
  output logic        last_multiple,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        busy
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t     state, state_d;
  logic [7:0] rem_mask, rem_mask_d;

  logic [7:0] src;      // register list being worked on this cycle
  logic [7:0] hi;       // one-hot of the highest set bit of src
  logic [7:0] rest;     // src with the issued bit removed
  logic       is_last;
  logic       is_multi;
  logic [15:0] uop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rem_mask <= 8'h00;
    end else begin
      state    <= state_d;
      rem_mask <= rem_mask_d;
    end
  end

  always_comb begin
    src = (state == SEQ) ? rem_mask : ir_in[7:0];
    hi  = 8'h00;
    // Later (higher) indices overwrite earlier ones, so the MSB wins.
    for (int i = 0; i < 8; i++) begin
      if (src[i]) begin
        hi    = 8'h00;
        hi[i] = 1'b1;
      end
    end
    rest     = src & ~hi;
    is_last  = (rest == 8'h00);
    uop      = {ir_in[15:9], 1'b0, hi};
    is_multi = ir_valid && ((ir_in[15:12] == OPC_LM) || (ir_in[15:12] == OPC_SM));
  end

  always_comb begin
    state_d        = state;
    rem_mask_d     = rem_mask;
    ir_out         = ir_in;
    first_multiple = 1'b0;
    last_multiple  = 1'b0;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    busy           = 1'b0;

    case (state)
      IDLE: begin
        if (is_multi) begin
          if (src == 8'h00) begin
            ir_out = NOP_IR;
          end else begin
            ir_out         = uop;
            first_multiple = 1'b1;
            if (is_last) begin
              last_multiple = 1'b1;
            end else begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              state_d     = SEQ;
              rem_mask_d  = rest;
            end
          end
        end
      end
      SEQ: begin
        busy   = 1'b1;
        ir_out = uop;
        if (is_last) begin
          last_multiple = 1'b1;
          state_d       = IDLE;
          rem_mask_d    = 8'h00;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          rem_mask_d  = rest;
        end
      end
      default: begin
        state_d    = IDLE;
        rem_mask_d = 8'h00;
      end
    endcase

    // The in-flight micro-op on a flush is discarded downstream; only the
    // sequencer state and the enables need overriding here.
    if (flush) begin
      state_d     = IDLE;
      rem_mask_d  = 8'h00;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end else if (stall) begin
      state_d     = state;
      rem_mask_d  = rem_mask;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end

    // Outputs follow reset combinationally so they settle before any clock edge.
    if (!reset) begin
      ir_out         = NOP_IR;
      first_multiple = 1'b0;
      last_multiple  = 1'b0;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - directed self-checking bench for lm_sm_sequencer
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_in;
  logic        ir_valid;
  logic        stall;
  logic        flush;
  logic [15:0] ir_out;
  logic        first_multiple;
  logic        last_multiple;
  logic        pc_write;
  logic        if_id_write;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // {ir_out, first, last, pc_write, if_id_write, busy}
  logic [20:0] obs;
  assign obs = {ir_out, first_multiple, last_multiple, pc_write, if_id_write, busy};

  lm_sm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .ir_valid       (ir_valid),
    .stall          (stall),
    .flush          (flush),
    .ir_out         (ir_out),
    .first_multiple (first_multiple),
    .last_multiple  (last_multiple),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ir_in = 16'h1234; ir_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    #2;
    checks++;
    if (obs !== {16'hF000, 5'b00110}) begin
      $display("FAIL reset_outputs got %h want %h", obs, {16'hF000, 5'b00110}); errors++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    ir_in = 16'h1234; ir_valid = 1'b1;
    #2;
    checks++;
    if (obs !== {16'h1234, 5'b00110}) begin
      $display("FAIL pass_add got %h want %h", obs, {16'h1234, 5'b00110}); errors++;
    end
    ir_in = 16'h64A1; ir_valid = 1'b0;
    #2;
    checks++;
    if (obs !== {16'h64A1, 5'b00110}) begin
      $display("FAIL pass_invalid_lm got %h want %h", obs, {16'h64A1, 5'b00110}); errors++;
    end
    ir_in = 16'h1234; ir_valid = 1'b1; stall = 1'b1;
    #2;
    checks++;
    if (obs !== {16'h1234, 5'b00000}) begin
      $display("FAIL pass_stall got %h want %h", obs, {16'h1234, 5'b00000}); errors++;
    end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_lm_three();
    ir_in = 16'h64A1; ir_valid = 1'b1;
    #2;
    checks++;
    if (obs !== {16'h6480, 5'b10000}) begin
      $display("FAIL lm3_c0 got %h want %h", obs, {16'h6480, 5'b10000}); errors++;
    end
    tick();
    checks++;
    if (obs !== {16'h6420, 5'b00001}) begin
      $display("FAIL lm3_c1 got %h want %h", obs, {16'h6420, 5'b00001}); errors++;
    end
    tick();
    checks++;
    if (obs !== {16'h6401, 5'b01111}) begin
      $display("FAIL lm3_c2 got %h want %h", obs, {16'h6401, 5'b01111}); errors++;
    end
    tick();
    ir_in = 16'h1234;
    #2;
    checks++;
    if (obs !== {16'h1234, 5'b00110}) begin
      $display("FAIL lm3_next got %h want %h", obs, {16'h1234, 5'b00110}); errors++;
    end
    tick();
  endtask

  task automatic test_single_and_empty();
    ir_in = 16'h7E01;
    #2;
    checks++;
    if (obs !== {16'h7E01, 5'b11110}) begin
      $display("FAIL sm_single got %h want %h", obs, {16'h7E01, 5'b11110}); errors++;
    end
    tick();
    ir_in = 16'h6000;
    #2;
    checks++;
    if (obs !== {16'hF000, 5'b00110}) begin
      $display("FAIL lm_empty got %h want %h", obs, {16'hF000, 5'b00110}); errors++;
    end
    tick();
    ir_in = 16'h1234;
    #2;
    checks++;
    if (obs !== {16'h1234, 5'b00110}) begin
      $display("FAIL after_empty got %h want %h", obs, {16'h1234, 5'b00110}); errors++;
    end
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] tail [5];
    int cycles;
    tail = '{16'h6420, 16'h6410, 16'h6408, 16'h6404, 16'h6402};
    ir_in = 16'h64FF;
    cycles = 1;
    #2;
    checks++;
    if (obs !== {16'h6480, 5'b10000}) begin
      $display("FAIL st_c0 got %h want %h", obs, {16'h6480, 5'b10000}); errors++;
    end
    tick(); cycles++;
    checks++;
    if (obs !== {16'h6440, 5'b00001}) begin
      $display("FAIL st_c1 got %h want %h", obs, {16'h6440, 5'b00001}); errors++;
    end
    tick(); cycles++;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (obs !== {16'h6420, 5'b00001}) begin
        $display("FAIL st_hold%0d got %h want %h", i, obs, {16'h6420, 5'b00001}); errors++;
      end
      tick(); cycles++;
    end
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (obs !== {tail[i], 5'b00001}) begin
        $display("FAIL st_tail%0d got %h want %h", i, obs, {tail[i], 5'b00001}); errors++;
      end
      tick(); cycles++;
    end
    checks++;
    if (obs !== {16'h6401, 5'b01111}) begin
      $display("FAIL st_last got %h want %h", obs, {16'h6401, 5'b01111}); errors++;
    end
    checks++;
    if (cycles !== 10) begin
      $display("FAIL st_cycles got %0d want 10", cycles); errors++;
    end
    tick();
    ir_in = 16'h1234;
    #2;
    checks++;
    if (obs !== {16'h1234, 5'b00110}) begin
      $display("FAIL st_next got %h want %h", obs, {16'h1234, 5'b00110}); errors++;
    end
    tick();
  endtask

  task automatic test_flush();
    ir_in = 16'h64FF;
    #2;
    checks++;
    if (obs !== {16'h6480, 5'b10000}) begin
      $display("FAIL fl_c0 got %h want %h", obs, {16'h6480, 5'b10000}); errors++;
    end
    tick();
    stall = 1'b1; flush = 1'b1;
    #2;
    checks++;
    if (obs !== {16'h6440, 5'b00111}) begin
      $display("FAIL fl_c1 got %h want %h", obs, {16'h6440, 5'b00111}); errors++;
    end
    tick();
    stall = 1'b0; flush = 1'b0; ir_in = 16'h1234;
    #2;
    checks++;
    if (obs !== {16'h1234, 5'b00110}) begin
      $display("FAIL fl_c2 got %h want %h", obs, {16'h1234, 5'b00110}); errors++;
    end
    tick();
    // Flush on the first micro-op in IDLE must keep the sequencer in IDLE.
    ir_in = 16'h64A1; flush = 1'b1;
    #2;
    checks++;
    if (obs !== {16'h6480, 5'b10110}) begin
      $display("FAIL fl_idle got %h want %h", obs, {16'h6480, 5'b10110}); errors++;
    end
    tick();
    flush = 1'b0;
    #2;
    checks++;
    if (obs !== {16'h6480, 5'b10000}) begin
      $display("FAIL fl_idle_reissue got %h want %h", obs, {16'h6480, 5'b10000}); errors++;
    end
    // Let that reissued sequence drain.
    tick(); tick();
    ir_in = 16'h1234;
    tick();
  endtask

  task automatic test_async_reset();
    ir_in = 16'h64A1;
    tick();
    checks++;
    if (obs !== {16'h6420, 5'b00001}) begin
      $display("FAIL ar_seq got %h want %h", obs, {16'h6420, 5'b00001}); errors++;
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== {16'hF000, 5'b00110}) begin
      $display("FAIL ar_async got %h want %h", obs, {16'hF000, 5'b00110}); errors++;
    end
    tick();
    reset = 1'b1;
    #2;
    checks++;
    if (obs !== {16'h6480, 5'b10000}) begin
      $display("FAIL ar_restart got %h want %h", obs, {16'h6480, 5'b10000}); errors++;
    end
    tick();
    checks++;
    if (obs !== {16'h6420, 5'b00001}) begin
      $display("FAIL ar_c1 got %h want %h", obs, {16'h6420, 5'b00001}); errors++;
    end
    tick();
    checks++;
    if (obs !== {16'h6401, 5'b01111}) begin
      $display("FAIL ar_c2 got %h want %h", obs, {16'h6401, 5'b01111}); errors++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lm_three();
    test_single_and_empty();
    test_stall();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
